control_mult_acumulador: RTL
============================

Name: control_mult_acumulador

Overview:
- Control unit and partial-product accumulator for the shift-and-add multiplier.
- Drives the `load`/`shift` controls of the multiplicand left-shift register and the multiplier right-shift register.
- Consumes their outputs: the shifted multiplicand and the multiplier LSB.
- Accumulates the partial products and flags completion to the processor.

Parameters:
- WIDTH, 8: operand width in bits. Product and multiplicand paths are 2*WIDTH bits.

Ports:
- clk  in  1  processor clock; this block updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- init  in  1  start request, sampled only in IDLE.
- lsb_b  in  1  LSB of the multiplier right-shift register output.
- a_shifted  in  2*WIDTH  multiplicand left-shift register output.
- load  out  1  load strobe to both shift registers.
- shift  out  1  shift strobe to both shift registers.
- pp  out  2*WIDTH  accumulated product.
- busy  out  1  high in every state except IDLE.
- done  out  1  completion pulse.

Behaviour:
- Reset (asynchronous, immediate, also mid-operation):
  - state = IDLE, count = 0, pp = 0, load = shift = busy = done = 0.
- Clocking and timing:
  - All state, count and pp updates happen on the rising edge of clk.
  - `load`/`shift` are registered Moore outputs of the state.
  - The shift registers act on the following falling edge, so `lsb_b` and `a_shifted` are stable at the next rising edge.
- States and transitions:
  - IDLE: outputs 0. init=1 -> LOAD. init=0 -> stay.
  - LOAD: load=1; pp <= 0 and count <= 0 on exit. -> CHECK.
  - CHECK: no strobes. lsb_b=1 -> ADD. lsb_b=0 -> SHIFT.
  - ADD: pp <= pp + a_shifted on exit, truncated to 2*WIDTH bits (cannot overflow for valid operands). -> SHIFT.
  - SHIFT: shift=1; count <= count+1.
    - count == WIDTH-1 -> DONE.
    - otherwise -> CHECK.
  - DONE: done=1 for exactly one cycle. -> IDLE.
- Counter: $clog2(WIDTH)+1 bits. Exactly WIDTH SHIFT states per operation.
- Latency, measured from the edge E0 that samples init=1 in IDLE:
  - DONE is entered at edge E(1 + 2*WIDTH + k), where k = number of 1-bits in the multiplier.
  - WIDTH=8: multiplier 0x00 -> E17; multiplier 0xFF -> E25.
- pp after DONE: holds its value until the next LOAD. IDLE never clears pp.
- init while busy (LOAD..DONE, including the DONE cycle): ignored. No queuing.
- load and shift: never high in the same cycle. Each is at most one cycle wide per state visit.
- busy: falls in the same cycle that the state returns to IDLE, i.e. the cycle after done.

Test Plan:
- Multiply 13 × 11 (WIDTH=8): shift registers loaded with 13 and 11, init pulse -> pp=143 when done pulses; done at E(17+3)=E20; exactly 8 shift pulses and 1 load pulse.
- Multiply 0 × 0x5A and 0x5A × 0 -> pp=0. First case: done at E(17+4)=E21. Second case: done at E17, with no ADD state visited.
- Multiply 255 × 255 -> pp=65025 (0xFE01); done at E25; no truncation.
- init held high for 40 cycles during 13 × 11 -> one operation only, pp=143. A second operation starts only from IDLE and again yields pp=143.
- Reset asserted asynchronously mid-ADD (between clock edges) -> pp, busy, load and shift go to 0 immediately. After release and a new init, 7 × 9 -> pp=63.
- Back-to-back operations: 3 × 5, then init in the first IDLE cycle for 6 × 6 -> pp=15 held through IDLE until the second LOAD, then pp=36; one done pulse per operation.

Source files
------------

// File: rtl/control_mult_acumulador.sv
// Sequencer and partial-product accumulator for a shift-and-add multiplier.
// Strobes the external operand shift registers and sums the shifted multiplicand.
module control_mult_acumulador #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init,
    input  logic                 lsb_b,
    input  logic [2*WIDTH-1:0]   a_shifted,
    output logic                 load,
    output logic                 shift,
    output logic [2*WIDTH-1:0]   pp,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        ADD,
        SHIFT,
        DONE
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   count_reg;

    // Strobes are computed from the next state so they are high exactly while
    // the FSM sits in the matching state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            count_reg <= '0;
            pp        <= '0;
            load      <= 1'b0;
            shift     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            load  <= 1'b0;
            shift <= 1'b0;
            done  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (init) begin
                        state_reg <= LOAD;
                        load      <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                LOAD: begin
                    pp        <= '0;
                    count_reg <= '0;
                    state_reg <= CHECK;
                end
                CHECK: begin
                    if (lsb_b) begin
                        state_reg <= ADD;
                    end else begin
                        state_reg <= SHIFT;
                        shift     <= 1'b1;
                    end
                end
                ADD: begin
                    pp        <= pp + a_shifted;
                    state_reg <= SHIFT;
                    shift     <= 1'b1;
                end
                SHIFT: begin
                    count_reg <= count_reg + 1'b1;
                    if (count_reg == LAST_COUNT) begin
                        state_reg <= DONE;
                        done      <= 1'b1;
                    end else begin
                        state_reg <= CHECK;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
